// File: rtl/sample_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_stream_fifo
// Purpose  : Valid/ready stream FIFO with DEPTH entries. Output data is read
//            straight from registered storage, and ready is a registered flag,
//            so there is no combinational path from input to output.
//            An accepted beat into an empty FIFO is presented on the next
//            cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : payload width in bits (1..128)
//   DEPTH      : number of storage entries (power of two, 2..256)
//   CNT_WIDTH  : width of the statistics counters
// Ports
//   clk              in   1            sole clock, rising edge
//   reset            in   1            synchronous active-high reset
//   stream_in_valid  in   1            producer has a beat
//   stream_in_ready  out  1            FIFO can accept a beat
//   stream_in_data   in   DATA_WIDTH   input payload
//   stream_out_valid out  1            FIFO presents a beat
//   stream_out_ready in   1            consumer takes the beat
//   stream_out_data  out  DATA_WIDTH   oldest stored entry
//   level            out  log2(D)+1    number of entries held
//   full             out  1            level == DEPTH
//   empty            out  1            level == 0
//   in_beats         out  CNT_WIDTH    saturating count of accepted beats
//   out_beats        out  CNT_WIDTH    saturating count of delivered beats
// Build option
//   SAMPLE_STREAM_FIFO_STATS_EN : when defined, adds in_beats / out_beats and
//                                 their counters; when undefined they are
//                                 absent.
// ============================================================================
module sample_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stream_in_valid,
    output logic                        stream_in_ready,
    input  logic [DATA_WIDTH-1:0]       stream_in_data,
    output logic                        stream_out_valid,
    input  logic                        stream_out_ready,
    output logic [DATA_WIDTH-1:0]       stream_out_data,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        full,
    output logic                        empty
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]        in_beats,
    output logic [CNT_WIDTH-1:0]        out_beats
`endif
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_LW = C_AW + 1;

    localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);
    localparam logic [C_LW-1:0] C_LVL_ONE = C_LW'(1);
    localparam logic [C_LW-1:0] C_LVL_MAX = C_LW'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [C_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [C_LW-1:0]       level_q,  level_d;
    // Ready is its own register so it can stay low throughout reset and
    // rise on the first clean edge, independent of the consumer side.
    logic                  in_ready_q, in_ready_d;

    logic w_accept;
    logic w_deliver;

    // No transfer of either kind is allowed to happen in a reset cycle.
    assign w_accept  = stream_in_valid  && in_ready_q           && !reset;
    assign w_deliver = stream_out_ready && (level_q != '0)      && !reset;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        in_ready_d = in_ready_q;

        // Pointers are exactly log2(DEPTH) bits, so the increment wraps
        // from DEPTH-1 to 0 on its own.
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_deliver) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        case ({w_accept, w_deliver})
            2'b10:   level_d = level_q + C_LVL_ONE;
            2'b01:   level_d = level_q - C_LVL_ONE;
            default: level_d = level_q;
        endcase

        in_ready_d = (level_d != C_LVL_MAX);
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= stream_in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all taken from registered state)
    // ------------------------------------------------------------------------
    assign stream_in_ready  = in_ready_q;
    assign stream_out_valid = (level_q != '0);
    assign stream_out_data  = mem_q[rd_ptr_q];
    assign level            = level_q;
    assign full             = (level_q == C_LVL_MAX);
    assign empty            = (level_q == '0);

    // ------------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------------
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] in_beats_q,  in_beats_d;
    logic [CNT_WIDTH-1:0] out_beats_q, out_beats_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        in_beats_d  = in_beats_q;
        out_beats_d = out_beats_q;
        if (w_accept && (in_beats_q != '1)) begin
            in_beats_d = in_beats_q + C_CNT_ONE;
        end
        if (w_deliver && (out_beats_q != '1)) begin
            out_beats_d = out_beats_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_beats_q  <= '0;
            out_beats_q <= '0;
        end else begin
            in_beats_q  <= in_beats_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign in_beats  = in_beats_q;
    assign out_beats = out_beats_q;
`else
    // Counter width has no consumer in this build.
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = (CNT_WIDTH > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_stream_fifo
// Purpose  : Self-checking bench for sample_stream_fifo (DEPTH=4, 8-bit data,
//            4-bit counters). Expected behaviour comes from a queue-based
//            reference model of the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_stream_fifo;

    localparam int DEPTH = 4;
    localparam int CMAX  = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       stream_in_valid;
    logic       stream_in_ready;
    logic [7:0] stream_in_data;
    logic       stream_out_valid;
    logic       stream_out_ready;
    logic [7:0] stream_out_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    logic [3:0] in_beats;
    logic [3:0] out_beats;
`endif

    always #5 clk = ~clk;

    sample_stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stream_in_valid  (stream_in_valid),
        .stream_in_ready  (stream_in_ready),
        .stream_in_data   (stream_in_data),
        .stream_out_valid (stream_out_valid),
        .stream_out_ready (stream_out_ready),
        .stream_out_data  (stream_out_data),
        .level            (level),
        .full             (full),
        .empty            (empty)
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        ,
        .in_beats         (in_beats),
        .out_beats        (out_beats)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus "ready allowed" flag that
    // drops in reset and comes back after the first non-reset edge.
    logic [7:0] mq[$];
    bit         m_rdy_en;
    int         m_in;
    int         m_out;

    // Per-cycle observation of the last drive() call.
    bit         exp_del, obs_del;
    logic [7:0] exp_pop, obs_pop;

    // Apply one cycle of inputs, advance past the edge, update the model.
    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        bit acc;
        stream_in_valid  = v;
        stream_in_data   = d;
        stream_out_ready = r;
        #1;
        obs_del = stream_out_valid && r && !reset;
        obs_pop = stream_out_data;
        exp_del = r && (mq.size() > 0) && !reset;
        exp_pop = exp_del ? mq[0] : 8'h00;
        acc     = v && m_rdy_en && (mq.size() < DEPTH) && !reset;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_rdy_en = 1'b0;
            m_in     = 0;
            m_out    = 0;
        end else begin
            if (exp_del) begin
                void'(mq.pop_front());
                if (m_out < CMAX) m_out++;
            end
            if (acc) begin
                mq.push_back(d);
                if (m_in < CMAX) m_in++;
            end
            m_rdy_en = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 8'h33, 1'b1);
        drive(1'b1, 8'h33, 1'b1);
        n_vec++;
        if (level !== 3'd0) begin
            n_err++; $display("FAIL reset_level got=%0d exp=0", level);
        end
        n_vec++;
        if ({empty, full, stream_in_ready, stream_out_valid} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags got empty=%b full=%b rdy=%b vld=%b exp 1 0 0 0",
                     empty, full, stream_in_ready, stream_out_valid);
        end
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        n_vec++;
        if (in_beats !== 4'd0 || out_beats !== 4'd0) begin
            n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", in_beats, out_beats);
        end
`endif
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        n_vec++;
        if (stream_in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_rise got=%b exp=1", stream_in_ready);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_pass_through();
        drive(1'b1, 8'hA5, 1'b0);
        n_vec++;
        if (stream_out_valid !== 1'b1 || stream_out_data !== 8'hA5 || level !== 3'd1) begin
            n_err++;
            $display("FAIL pass_through got vld=%b data=%h lvl=%0d exp 1 a5 1",
                     stream_out_valid, stream_out_data, level);
        end
        drive(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (!obs_del || obs_pop !== 8'hA5 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL pass_drain got del=%b data=%h empty=%b exp 1 a5 1",
                     obs_del, obs_pop, empty);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
        n_vec++;
        if (full !== 1'b1 || stream_in_ready !== 1'b0 || level !== 3'd4) begin
            n_err++;
            $display("FAIL fill_full got full=%b rdy=%b lvl=%0d exp 1 0 4",
                     full, stream_in_ready, level);
        end
        drive(1'b1, 8'h05, 1'b0);
        n_vec++;
        if (level !== 3'd4) begin
            n_err++; $display("FAIL fill_overflow_ignored got lvl=%0d exp=4", level);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_vec++;
            if (!obs_del || obs_pop !== 8'(i)) begin
                n_err++; $display("FAIL fill_drain[%0d] got del=%b data=%h exp 1 %h",
                                  i, obs_del, obs_pop, 8'(i));
            end
        end
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++; $display("FAIL fill_empty_after got=%b exp=1", empty);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stream_wrap();
        drive(1'b1, 8'd0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            drive(i < 20, 8'(i), 1'b1);
            n_vec++;
            if (!obs_del || obs_pop !== 8'(i - 1)) begin
                n_err++; $display("FAIL stream_out[%0d] got del=%b data=%h exp 1 %h",
                                  i - 1, obs_del, obs_pop, 8'(i - 1));
            end
            if (i < 20) begin
                n_vec++;
                if (level !== 3'd1) begin
                    n_err++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, level);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b1, 8'hCC, 1'b1);
        n_vec++;
        if (level !== 3'd3 || stream_in_ready !== 1'b1) begin
            n_err++; $display("FAIL push_pop_full got lvl=%0d rdy=%b exp 3 1",
                              level, stream_in_ready);
        end
        while (mq.size() > 0) begin
            drive(1'b0, 8'h00, 1'b1);
            n_vec++;
            if (obs_del !== exp_del || obs_pop !== exp_pop) begin
                n_err++; $display("FAIL push_pop_drain got %b/%h exp %b/%h",
                                  obs_del, obs_pop, exp_del, exp_pop);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
        n_vec++;
        if (level !== 3'd3) begin
            n_err++; $display("FAIL mid_level_pre got=%0d exp=3", level);
        end
        reset = 1'b1;
        drive(1'b1, 8'hEE, 1'b1);
        reset = 1'b0;
        n_vec++;
        if (level !== 3'd0 || stream_out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got lvl=%0d vld=%b exp 0 0",
                              level, stream_out_valid);
        end
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        n_vec++;
        if (in_beats !== 4'd0 || out_beats !== 4'd0) begin
            n_err++; $display("FAIL mid_reset_cnt got=%0d/%0d exp=0/0", in_beats, out_beats);
        end
`endif
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h7E, 1'b0);
        n_vec++;
        if (stream_out_valid !== 1'b1 || stream_out_data !== 8'h7E || level !== 3'd1) begin
            n_err++; $display("FAIL mid_first_after got vld=%b data=%h lvl=%0d exp 1 7e 1",
                              stream_out_valid, stream_out_data, level);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50);
            reset = 1'b0;
            n_vec++;
            if (obs_del !== exp_del || (exp_del && obs_pop !== exp_pop)) begin
                n_err++; $display("FAIL rand_pop[%0d] got %b/%h exp %b/%h",
                                  c, obs_del, obs_pop, exp_del, exp_pop);
            end
            n_vec++;
            if (level !== 3'(mq.size()) || full !== (mq.size() == DEPTH) ||
                empty !== (mq.size() == 0) || stream_out_valid !== (mq.size() != 0) ||
                stream_in_ready !== (m_rdy_en && mq.size() < DEPTH)) begin
                n_err++; $display("FAIL rand_state[%0d] got lvl=%0d f=%b e=%b v=%b r=%b exp lvl=%0d",
                                  c, level, full, empty, stream_out_valid,
                                  stream_in_ready, mq.size());
            end
            if (mq.size() > 0) begin
                n_vec++;
                if (stream_out_data !== mq[0]) begin
                    n_err++; $display("FAIL rand_head[%0d] got=%h exp=%h",
                                      c, stream_out_data, mq[0]);
                end
            end
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
            n_vec++;
            if (in_beats !== 4'(m_in) || out_beats !== 4'(m_out)) begin
                n_err++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                                  c, in_beats, out_beats, m_in, m_out);
            end
`endif
        end
        while (mq.size() > 0) drive(1'b0, 8'h00, 1'b1);
    endtask

    // ------------------------------------------------------------------------
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    task automatic test_stats();
        do_reset();
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (in_beats !== 4'd15 || out_beats !== 4'd15) begin
            n_err++; $display("FAIL stats_saturate got=%0d/%0d exp=15/15", in_beats, out_beats);
        end
    endtask
`endif

    // ------------------------------------------------------------------------
    initial begin
        reset            = 1'b1;
        stream_in_valid  = 1'b0;
        stream_in_data   = 8'h00;
        stream_out_ready = 1'b0;
        m_rdy_en         = 1'b0;
        m_in             = 0;
        m_out            = 0;
        test_reset();
        test_pass_through();
        test_fill_full();
        test_stream_wrap();
        test_push_pop_full();
        test_reset_mid();
        test_random();
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
